// File: rtl/conv_pkg.sv
// Shared convolution-engine types: scheduler state encoding, sizing helpers and the pixel tag.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  function automatic int sq(input int x);
    return x * x;
  endfunction

  // Bits needed to index 0..x-1, never less than one.
  function automatic int nbits(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

  localparam int PIX_I_DIM = 8;
  localparam int PIX_BITS  = nbits(PIX_I_DIM);

  typedef struct packed {
    logic [PIX_BITS-1:0] row;
    logic [PIX_BITS-1:0] col;
  } pix_user_t;

endpackage

// File: rtl/conv_issue_reg.sv
// One-entry valid/ready pipeline register carrying data, user tag and last flag.
module conv_issue_reg #(
  parameter int DW = 16,
  parameter int UW = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [UW-1:0] in_user,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [UW-1:0] out_user,
  output logic          out_last
);

  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic [UW-1:0] user_p1;
  logic          last_p1;

  // Refill is allowed in the same cycle the held entry drains.
  assign in_ready = !vld_p1 || out_ready;

  // ---- stage p1: issue register ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      user_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
      user_p1 <= in_user;
      last_p1 <= in_last;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_user  = user_p1;
  assign out_last  = last_p1;

endmodule

// File: rtl/conv_sched.sv
// conv_sched: loads the kernel bank, streams (row,col)-tagged pixels to the multipliers, waits for drain.
// Define CONV_SCHED_PERF_EN to add the perf_stall / perf_cycles saturating counters.
module conv_sched
  import conv_pkg::*;
#(
  parameter int K_DIM  = 3,
  parameter int I_DIM  = 8,
  parameter int M_BITS = 16,
  parameter int K_SIZE = sq(K_DIM),
  parameter int I_BITS = nbits(I_DIM),
  parameter int F_BITS = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [F_BITS-1:0]                      cmd_frames,
  input  logic                                   cmd_reuse_k,
  input  logic [M_BITS-1:0]                      k_data,
  input  logic                                   k_valid,
  output logic                                   k_ready,
  input  logic [M_BITS-1:0]                      img_data,
  input  logic                                   img_valid,
  output logic                                   img_ready,
  output logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] kern_out,
  output logic [M_BITS-1:0]                      iss_data,
  output logic [1:0][I_BITS-1:0]                 iss_user,
  output logic                                   iss_last,
  output logic                                   iss_valid,
  input  logic                                   iss_ready,
  input  logic                                   out_done,
  output logic                                   busy,
  output logic                                   done
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]                            perf_stall,
  output logic [31:0]                            perf_cycles
`endif
);

  localparam int KIDX_W = nbits(K_SIZE);

  sched_state_t       state, state_nxt;
  logic [KIDX_W-1:0]  kidx;
  logic [I_BITS-1:0]  row, col;
  logic [F_BITS-1:0]  frames_left;
  logic               reuse;
  logic               img_stop;
  logic               stream_ok;
  logic               ir_in_ready;
  logic               pix_last;

  assign pix_last  = (row == I_BITS'(I_DIM - 1)) && (col == I_BITS'(I_DIM - 1));
  assign img_ready = stream_ok && ir_in_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    k_ready   = 1'b0;
    stream_ok = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_reuse_k ? STREAM : LOAD_K;
      end
      LOAD_K: begin
        k_ready = 1'b1;
        if (k_valid && kidx == KIDX_W'(K_SIZE - 1)) state_nxt = STREAM;
      end
      STREAM: begin
        stream_ok = !img_stop;
        if (iss_valid && iss_ready && iss_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_done) begin
          if (frames_left == F_BITS'(1)) state_nxt = IDLE;
          else                           state_nxt = reuse ? STREAM : LOAD_K;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: sequencing, kernel bank and pixel coordinates ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      kidx        <= '0;
      row         <= '0;
      col         <= '0;
      frames_left <= '0;
      reuse       <= 1'b0;
      img_stop    <= 1'b0;
      done        <= 1'b0;
      kern_out    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        frames_left <= (cmd_frames == '0) ? F_BITS'(1) : cmd_frames;
        reuse       <= cmd_reuse_k;
      end
      if (k_valid && k_ready) begin
        for (int i = 0; i < K_DIM; i++)
          for (int j = 0; j < K_DIM; j++)
            if (kidx == KIDX_W'(i * K_DIM + j)) kern_out[i][j] <= k_data;
        kidx <= (kidx == KIDX_W'(K_SIZE - 1)) ? '0 : kidx + KIDX_W'(1);
      end
      if (img_valid && img_ready) begin
        if (pix_last) begin
          row      <= '0;
          col      <= '0;
          img_stop <= 1'b1;
        end else if (col == I_BITS'(I_DIM - 1)) begin
          col <= '0;
          row <= row + I_BITS'(1);
        end else begin
          col <= col + I_BITS'(1);
        end
      end
      if (state == DRAIN) begin
        img_stop <= 1'b0;
        if (out_done) begin
          frames_left <= frames_left - F_BITS'(1);
          if (frames_left == F_BITS'(1)) done <= 1'b1;
        end
      end
    end
  end

  // ---- stage p1: issue register toward the multipliers ----
  conv_issue_reg #(
    .DW(M_BITS),
    .UW(2 * I_BITS)
  ) u_issue (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (stream_ok && img_valid),
    .in_ready (ir_in_ready),
    .in_data  (img_data),
    .in_user  ({row, col}),
    .in_last  (pix_last),
    .out_valid(iss_valid),
    .out_ready(iss_ready),
    .out_data (iss_data),
    .out_user (iss_user),
    .out_last (iss_last)
  );

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn || (cmd_valid && cmd_ready)) begin
      perf_stall  <= '0;
      perf_cycles <= '0;
    end else begin
      if (state != IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state == STREAM && iss_valid && !iss_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: directed commands, scoreboard of expected issues, per-cycle checks.
`timescale 1ns/1ps
module tb_conv_sched;
  import conv_pkg::*;

  localparam int K_DIM  = 3;
  localparam int I_DIM  = 8;
  localparam int M_BITS = 16;
  localparam int F_BITS = 8;
  localparam int I_BITS = nbits(I_DIM);
  localparam int NPIX   = I_DIM * I_DIM;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [F_BITS-1:0] cmd_frames = '0;
  logic cmd_reuse_k = 1'b0;
  logic [M_BITS-1:0] k_data = '0;
  logic k_valid = 1'b0;
  logic k_ready;
  logic [M_BITS-1:0] img_data = '0;
  logic img_valid = 1'b0;
  logic img_ready;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] kern_out;
  logic [M_BITS-1:0] iss_data;
  logic [1:0][I_BITS-1:0] iss_user;
  logic iss_last, iss_valid;
  logic iss_ready = 1'b0;
  logic out_done = 1'b0;
  logic busy, done;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_stall, perf_cycles;
`endif

  conv_sched dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_frames(cmd_frames), .cmd_reuse_k(cmd_reuse_k),
    .k_data(k_data), .k_valid(k_valid), .k_ready(k_ready),
    .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .kern_out(kern_out),
    .iss_data(iss_data), .iss_user(iss_user), .iss_last(iss_last), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .out_done(out_done), .busy(busy), .done(done)
`ifdef CONV_SCHED_PERF_EN
    , .perf_stall(perf_stall), .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M_BITS-1:0] d;
    pix_user_t         u;
    logic              l;
  } exp_t;

  int total = 0;
  int bad = 0;

  logic [M_BITS-1:0] img_q[$];
  logic [M_BITS-1:0] k_q[$];
  exp_t exp_q[$];

  // Stimulus control
  int  rmode = 0;
  bit  auto_done = 0;
  bit  inject_done = 0;
  int  done_timer = 0;
  bit  no_k = 0;
  bit  img_hs = 0, k_hs = 0;

  // Observed history and model state
  int  iss_cnt = 0, last_cnt = 0, done_cnt = 0;
  int  m_frames = 0;
  bit  m_drain = 0, exp_done = 0, after_rst = 1;
  bit  prev_stall = 0, prev_khs = 0;
  logic [M_BITS-1:0] prev_data, last_data;
  logic [1:0][I_BITS-1:0] prev_user, last_user, first_user;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] prev_kern;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push_frame(input int base);
    exp_t e;
    for (int p = 0; p < NPIX; p++) begin
      img_q.push_back(M_BITS'(base + p));
      e.d = M_BITS'(base + p);
      e.u.row = PIX_BITS'(p / I_DIM);
      e.u.col = PIX_BITS'(p % I_DIM);
      e.l = (p == NPIX - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_kernel(input int base);
    for (int i = 0; i < K_DIM * K_DIM; i++) k_q.push_back(M_BITS'(base + i));
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input int frames, input bit reuse);
    int n = 0;
    cmd_frames = F_BITS'(frames);
    cmd_reuse_k = reuse;
    cmd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    step();
    cmd_valid = 1'b0;
    if (n >= 50) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input string nm);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 3000) begin step(); n++; end
    if (done_cnt == start) chk(nm, 0, 1);
  endtask

  task automatic wait_iss(input int target, input string nm);
    int n = 0;
    while (iss_cnt < target && n < 3000) begin step(); n++; end
    if (iss_cnt < target) chk(nm, iss_cnt, target);
  endtask

  // Input driver: advances stream queues on observed handshakes, shapes iss_ready and out_done.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (img_hs && img_q.size() > 0) void'(img_q.pop_front());
      if (k_hs && k_q.size() > 0) void'(k_q.pop_front());
      img_hs = 0;
      k_hs = 0;
      img_valid = (img_q.size() > 0);
      img_data  = img_valid ? img_q[0] : '0;
      k_valid   = (k_q.size() > 0);
      k_data    = k_valid ? k_q[0] : '0;
      iss_ready = (rmode == 0) ? 1'b1 : ~iss_ready;
      out_done = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) out_done = 1'b1;
      end
      if (inject_done) begin
        out_done = 1'b1;
        inject_done = 0;
      end
    end
  end

  // Compare process: DUT outputs against the frame-level model every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      m_frames = 0; m_drain = 0; exp_done = 0;
      prev_stall = 0; prev_khs = 0; after_rst = 1;
      img_hs = 0; k_hs = 0;
    end else begin
      chk("busy_vs_cmd_ready", busy, !cmd_ready);
      chk("done_pulse", done, exp_done);
      if (done) chk("busy_at_done", busy, 0);
      exp_done = 0;
      if (!after_rst && !prev_khs) chk("kern_hold", kern_out, prev_kern);
      if (prev_stall) begin
        chk("stall_valid", iss_valid, 1);
        chk("stall_data", iss_data, prev_data);
        chk("stall_user", iss_user, prev_user);
      end
      if (iss_valid && !iss_ready) chk("img_ready_blocked", img_ready, 0);
      if (no_k) chk("no_k_ready", k_ready, 0);
      if (m_drain) begin
        chk("drain_img_ready", img_ready, 0);
        chk("drain_k_ready", k_ready, 0);
        chk("drain_busy", busy, 1);
      end
      if (cmd_valid && cmd_ready) m_frames = (cmd_frames == 0) ? 1 : int'(cmd_frames);
      if (out_done && m_drain) begin
        m_drain = 0;
        m_frames--;
        if (m_frames == 0) exp_done = 1;
      end
      if (iss_valid && iss_ready) begin
        if (iss_cnt == 0) first_user = iss_user;
        iss_cnt++;
        if (exp_q.size() == 0) chk("unexpected_issue", iss_data, 0 - 1);
        else begin
          e = exp_q.pop_front();
          chk("iss_data", iss_data, e.d);
          chk("iss_user", iss_user, {e.u.row, e.u.col});
          chk("iss_last", iss_last, e.l);
        end
        if (iss_last) begin
          m_drain = 1;
          last_cnt++;
          last_data = iss_data;
          last_user = iss_user;
          if (auto_done) done_timer = 3;
        end
      end
      if (done) done_cnt++;
      img_hs = img_valid && img_ready;
      k_hs = k_valid && k_ready;
      prev_khs = k_hs;
      prev_stall = iss_valid && !iss_ready;
      prev_data = iss_data;
      prev_user = iss_user;
      prev_kern = kern_out;
      after_rst = 0;
    end
  end

  initial begin
    int c0, l0;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_k_ready", k_ready, 0);
    chk("rst_img_ready", img_ready, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_last", iss_last, 0);
    chk("rst_iss_data", iss_data, 0);
    chk("rst_iss_user", iss_user, 0);
    chk("rst_kern_out", kern_out, 0);
    step();
    rstn = 1'b1;
    step();

    // Single frame, kernel load, no stall
    rmode = 0; auto_done = 0; iss_cnt = 0; c0 = done_cnt;
    push_kernel(1);
    push_frame(0);
    send_cmd(1, 0);
    wait_iss(NPIX, "t1_issue_timeout");
    repeat (2) step();
    chk("t1_kern_1_2", kern_out[1][2], 6);
    chk("t1_kern_0_0", kern_out[0][0], 1);
    chk("t1_kern_2_2", kern_out[2][2], 9);
    chk("t1_iss_cnt", iss_cnt, NPIX);
    chk("t1_last_data", last_data, 63);
    chk("t1_last_user", last_user, {3'd7, 3'd7});
    chk("t1_first_user", first_user, 0);
    chk("t1_in_drain_busy", busy, 1);
    chk("t1_no_done_yet", done_cnt, c0);
    inject_done = 1;
    wait_done("t1_done_timeout");
    chk("t1_done_cnt", done_cnt, c0 + 1);

    // Backpressure: iss_ready toggles every cycle, kernel reused
    rmode = 1; auto_done = 1; no_k = 1; iss_cnt = 0;
    push_frame(100);
    send_cmd(1, 1);
    wait_done("t2_done_timeout");
    chk("t2_iss_cnt", iss_cnt, NPIX);
    chk("t2_exp_empty", exp_q.size(), 0);
    chk("t2_kern_kept", kern_out[1][2], 6);

    // Three frames with kernel reuse
    rmode = 0; iss_cnt = 0; c0 = done_cnt; l0 = last_cnt;
    push_frame(200);
    push_frame(300);
    push_frame(400);
    send_cmd(3, 1);
    wait_done("t3_done_timeout");
    repeat (6) step();
    chk("t3_iss_cnt", iss_cnt, 3 * NPIX);
    chk("t3_frames", last_cnt, l0 + 3);
    chk("t3_one_done", done_cnt, c0 + 1);

    // cmd_frames = 0 runs one frame
    iss_cnt = 0; c0 = done_cnt;
    push_frame(500);
    send_cmd(0, 1);
    wait_done("t4_done_timeout");
    repeat (4) step();
    chk("t4_iss_cnt", iss_cnt, NPIX);
    chk("t4_one_done", done_cnt, c0 + 1);
    chk("t4_idle", busy, 0);

    // out_done during STREAM is ignored
    iss_cnt = 0; c0 = done_cnt;
    push_frame(600);
    send_cmd(1, 1);
    wait_iss(20, "t5_issue_timeout");
    inject_done = 1;
    wait_done("t5_done_timeout");
    chk("t5_iss_cnt", iss_cnt, NPIX);
    chk("t5_one_done", done_cnt, c0 + 1);
    no_k = 0;

    // Reset at pixel 30, then restart with a fresh kernel
    iss_cnt = 0; c0 = done_cnt;
    push_kernel(1);
    push_frame(700);
    send_cmd(1, 0);
    wait_iss(30, "t6_issue_timeout");
    rstn = 1'b0;
    img_q.delete(); k_q.delete(); exp_q.delete();
    done_timer = 0;
    step();
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("t6_rst_iss_valid", iss_valid, 0);
    chk("t6_rst_kern_out", kern_out, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    chk("t6_rst_done", done, 0);
    chk("t6_no_done", done_cnt, c0);
    step();
    iss_cnt = 0;
    push_kernel(11);
    push_frame(800);
    send_cmd(1, 0);
    wait_done("t6_done_timeout");
    chk("t6_first_user", first_user, 0);
    chk("t6_iss_cnt", iss_cnt, NPIX);
    chk("t6_kern_1_2", kern_out[1][2], 16);
    chk("t6_kern_0_0", kern_out[0][0], 11);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
# conv_sched

Frame-level scheduler for the convolution engine. It accepts a command, loads the K_DIM×K_DIM kernel into a register bank driven onto the multiplier array, then streams I_DIM×I_DIM image pixels to the multipliers, tagging each pixel with its (row, col) coordinate and marking the final pixel. It holds off the next frame until the output controller has drained the full O_DIM×O_DIM result. It sits between the DMA-facing kernel and image streams and the multiplier array / output controller pair.

## Interface
- K_DIM, 3, kernel dimension
- I_DIM, 8, image dimension
- M_BITS, 16, data word width (floating-point bits)
- K_SIZE, sq(K_DIM), kernel element count
- I_BITS, nbits(I_DIM), image coordinate width
- F_BITS, 8, frame-count width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_frames  in  F_BITS  number of frames to run; 0 is treated as 1
- cmd_reuse_k  in  1  skip the kernel load and keep the current kernel bank
- k_data / k_valid / k_ready  in / in / out  M_BITS / 1 / 1  kernel stream, row-major
- img_data / img_valid / img_ready  in / in / out  M_BITS / 1 / 1  image stream, row-major
- kern_out  out  [K_DIM][K_DIM][M_BITS]  kernel bank to the multipliers
- iss_data  out  M_BITS  pixel issued to the multipliers
- iss_user  out  [2][I_BITS]  {row, col} of the issued pixel
- iss_last / iss_valid / iss_ready  out / out / in  1 / 1 / 1  issue handshake; iss_last marks the final pixel of a frame
- out_done  in  1  output controller accepted its last beat (out_last & out_valid & out_ready)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the command completes

## Operation
- States: IDLE, LOAD_K, STREAM, DRAIN.
- IDLE
  - cmd_ready=1.
  - On cmd handshake, latch frames_left = max(cmd_frames, 1) and latch reuse.
  - Go to STREAM if cmd_reuse_k is set, otherwise go to LOAD_K.
- LOAD_K
  - k_ready=1.
  - Each accepted beat writes kern_out[kidx/K_DIM][kidx%K_DIM], then kidx increments.
  - On the K_SIZE-th beat: kidx←0, go to STREAM.
- STREAM
  - img_ready = !iss_valid || iss_ready.
  - An accepted pixel loads the issue register: data, user={row,col}, last=(row==I_DIM-1 && col==I_DIM-1).
  - col increments; it wraps to 0 at I_DIM-1 and row increments.
  - The last accepted pixel clears row/col and stops further image acceptance (img_ready=0).
  - When the last pixel handshakes on the issue port, go to DRAIN.
- DRAIN
  - Wait for out_done; all ready outputs are low.
  - On out_done, frames_left decrements.
  - If frames_left reaches 0: done=1 for one cycle, go to IDLE.
  - Otherwise go to STREAM if reuse is set, else LOAD_K.
- out_done outside DRAIN is ignored.
- kern_out is stable outside LOAD_K and holds across commands.
- cmd_valid outside IDLE is not accepted.

## Timing
- Reset values:
  - state=IDLE; cmd_ready=1 (combinational from IDLE); busy=0; done=0.
  - k_ready=0, img_ready=0, iss_valid=0, iss_last=0.
  - iss_data=0, iss_user=0, kern_out all 0.
  - Counters (kidx, row, col, frames_left) = 0.
- Reset mid-frame abandons the frame with no done pulse; the kernel bank is cleared.
- Pixel latency: 1 cycle from img handshake to iss_valid.
- Throughput: 1 pixel/cycle while iss_ready=1.
- Issue register: iss_valid stays set and its payload holds until iss_ready. Simultaneous drain and refill in the same cycle is allowed (no bubble).
- Command to first issue: K_SIZE+1 cycles minimum with kernel load, 1 cycle with reuse.
- DRAIN→next frame: 1 cycle after out_done.
- done asserts the cycle after out_done; busy falls together with done.

## Configuration
- CONV_SCHED_PERF_EN: when defined, adds two outputs:
  - perf_stall (32 bits): counts STREAM cycles with iss_valid && !iss_ready.
  - perf_cycles (32 bits): counts all non-IDLE cycles.
  - Both clear on reset and on command acceptance, and saturate at all-ones.
- When not defined, neither the ports nor the counters exist; behaviour is otherwise identical.

## Structure
- Shared package conv_pkg holds:
  - sched_state_t enum (2 bits).
  - sq/nbits functions (shared with existing utils).
  - pix_user_t packed struct {row, col}.
- One sub-module, conv_issue_reg: a one-entry valid/ready pipeline register with data, user and last fields. It is reusable by other stream stages.

## Test plan
- Single frame, no stall: cmd_frames=1, kernel 1..9, pixels 0..63 → kern_out[1][2]=6; 64 issues with iss_user row-major (0,0)…(7,7); iss_last only on (7,7) carrying data 63; state enters DRAIN.
- Backpressure: iss_ready toggles every cycle → no pixel dropped or duplicated; iss_data holds while stalled; img_ready=0 whenever the issue register is full and blocked.
- Multi-frame with reuse: cmd_frames=3, cmd_reuse_k=1 after a prior load → no k_ready assertion; 3×64 issues; exactly one done pulse, one cycle after the third out_done.
- cmd_frames=0 → runs exactly one frame.
- out_done pulsed during STREAM → ignored; a frame ends only on the DRAIN out_done.
- Reset asserted at pixel 30 → next cycle: IDLE, iss_valid=0, kern_out=0, no done; a new command restarts at (0,0).
